spi_boot_host: RTL and testbench
================================

# spi_boot_host

SPI controller that drives the boot-load command protocol from the host side: it turns single-word requests into framed SPI transactions (Stop, Run, Set Address, Write IMEM) for the core's SPI target loader. It sits in test harnesses and in a host-side FPGA or bridge that programs a Shrike-V device. It can also capture the byte the target returns on MISO, which is the low byte of the core PC.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles. Legal range 2..255.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: high only in IDLE. The request is accepted on a `clk` edge where valid and ready are both high.
- `i_req_op` in 2: 0 = Stop (0x10), 1 = Run (0x11), 2 = Set Address (0x20), 3 = Write IMEM (0x30).
- `i_req_data` in 32: address or word for ops 2 and 3. Ignored for ops 0 and 1.
- `o_busy` out 1: high from acceptance until the cycle after `o_done`.
- `o_done` out 1: one-cycle pulse when the transaction completes.
- `o_rx_byte` out 8: last MISO byte of the most recent transaction.
- `spi_ss_n` out 1: chip select, active low.
- `spi_sck` out 1: SPI clock.
- `spi_mosi` out 1: controller data out.
- `spi_miso` in 1: target data in.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- MOSI changes only while SCK is low. MISO is sampled on the `clk` edge where SCK rises.
- Frame length:
  - Ops 0 and 1: one byte, the command byte.
  - Ops 2 and 3: five bytes, the command byte then `i_req_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- `spi_ss_n` stays low for the whole frame. SCK runs continuously across byte boundaries, with no inter-byte gap.
- On acceptance, op and data are latched into a 40-bit shift register and a byte count N (1 or 5) is recorded. Later changes to the inputs have no effect.
- States:
  - IDLE: ss_n=1, sck=0. Goes to SETUP on acceptance.
  - SETUP: ss_n=0, mosi = bit 7 of byte 0. Lasts `CLK_DIV` cycles, then goes to SHIFT.
  - SHIFT: toggles SCK every `CLK_DIV` cycles for 16·N half-periods.
    - On a rising edge: sample MISO.
    - On a falling edge: shift out the next bit.
    - After the last falling edge, go to HOLD.
  - HOLD: sck=0, ss_n=0. Lasts `CLK_DIV` cycles, then goes to GAP with ss_n=1.
  - GAP: ss_n=1. Lasts `CLK_DIV` cycles. On its final cycle, `o_done` pulses and the state returns to IDLE.
- Reset values:
  - `spi_ss_n`=1, `spi_sck`=0, `spi_mosi`=0.
  - `o_busy`=0, `o_done`=0, `o_rx_byte`=0x00.
  - State IDLE, so `o_req_ready`=1.
- Reset asserted mid-frame forces all outputs to their reset values immediately (async). The partial frame is abandoned; the target resynchronises on the ss_n rise.
- A request held valid during busy waits. `o_req_ready` is low, and nothing is dropped or queued.

## Timing
- Acceptance edge E0 → `spi_ss_n` falls at E0 and mosi is valid at E0.
- First SCK rise at E0 + `CLK_DIV`.
- `spi_ss_n` low for exactly `CLK_DIV`·(16N+2) cycles.
- `o_done` pulses at E0 + `CLK_DIV`·(16N+3) − 1. `o_req_ready` rises on the following cycle.
- Frame durations at the default `CLK_DIV`=4:
  - Single-byte frame: ss_n low 72 cycles, done at cycle 75.
  - Five-byte frame: ss_n low 328 cycles, done at cycle 331.
- Minimum gap between frames (ss_n high) is `CLK_DIV` + 1 cycles.
- The target samples SCK through synchronizers in its own `clk` domain. `CLK_DIV` ≥ 4 is required when the host and target share a clock frequency.

## Configuration
- `SPI_BOOT_HOST_MISO_CAPTURE_EN`
- Defined:
  - MISO is shifted in on each SCK rise.
  - `o_rx_byte` updates with the final byte of the frame in the same cycle as `o_done`. For Set Address and Write IMEM frames this is the last of the 5 bytes.
- Undefined:
  - The MISO shift logic is omitted and `spi_miso` is ignored.
  - `o_rx_byte` is a constant 0x00.

## Test plan
- **Stop (op 0), `CLK_DIV`=4:** MOSI bits 0,0,0,1,0,0,0,0 sampled on SCK rises; 8 SCK pulses; ss_n low 72 cycles; a single `o_done` pulse at E0+75.
- **Write IMEM (op 3), data 0xDEADBEEF:** decoded MOSI bytes 0x30, DE, AD, BE, EF; SCK continuous across byte boundaries; 40 SCK pulses; `o_done` at E0+331.
- **Back-to-back requests (op 2 with 0x00000100, then op 1) with valid held high:** ready low throughout frame 1; ss_n high for 5 cycles between frames; second frame is byte 0x11.
- **Reset mid-frame:** assert `rst_n`=0 after byte 2 of a Write IMEM frame → same cycle ss_n=1, sck=0, mosi=0, busy=0, no `o_done`; a new Run request after release produces a clean frame.
- **MISO capture (macro defined):** MISO model returns 0xA5 on the last byte → `o_rx_byte`=0xA5 at `o_done`. With the macro undefined, `o_rx_byte` stays 0x00.
- **`CLK_DIV`=2 corner:** SCK half-period of 2 cycles; op 0 completes with ss_n low 36 cycles and done at E0+37.

Source files
------------

// File: rtl/spi_boot_host.sv
`timescale 1ns/1ps
// Host-side SPI mode-0 controller framing boot-loader commands (Stop/Run/Set Address/Write IMEM).
// Optional MISO byte capture is enabled by defining SPI_BOOT_HOST_MISO_CAPTURE_EN.
module spi_boot_host #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [1:0]  i_req_op,
   input  logic [31:0] i_req_data,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_rx_byte,
   output logic        spi_ss_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [6:0]  hp_q, hp_d;
   logic [6:0]  hp_last_q, hp_last_d;
   logic [39:0] sr_q, sr_d;
   logic        ss_n_q, ss_n_d;
   logic        sck_q, sck_d;
   logic        done_q, done_d;
   logic        tick;

   function automatic logic [7:0] cmd_byte(input logic [1:0] op);
      logic [7:0] c;
      case (op)
         2'd0:    c = 8'h10;
         2'd1:    c = 8'h11;
         2'd2:    c = 8'h20;
         default: c = 8'h30;
      endcase
      return c;
   endfunction

   assign tick = (cnt_q == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         hp_q      <= 7'd0;
         hp_last_q <= 7'd0;
         sr_q      <= 40'd0;
         ss_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         hp_last_q <= hp_last_d;
         sr_q      <= sr_d;
         ss_n_q    <= ss_n_d;
         sck_q     <= sck_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hp_d      = hp_q;
      hp_last_d = hp_last_q;
      sr_d      = sr_q;
      ss_n_d    = ss_n_q;
      sck_d     = sck_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (i_req_valid) begin
               state_d = S_SETUP;
               ss_n_d  = 1'b0;
               // Single-byte frames pad with zeros so MOSI returns low once shifted out.
               if (i_req_op[1]) begin
                  sr_d      = {cmd_byte(i_req_op), i_req_data};
                  hp_last_d = 7'd79;
               end else begin
                  sr_d      = {cmd_byte(i_req_op), 32'd0};
                  hp_last_d = 7'd15;
               end
            end
         end
         S_SETUP: begin
            cnt_d = cnt_q + 8'd1;
            if (tick) begin
               cnt_d   = 8'd0;
               state_d = S_SHIFT;
               sck_d   = 1'b1;
               hp_d    = 7'd0;
            end
         end
         S_SHIFT: begin
            cnt_d = cnt_q + 8'd1;
            if (tick) begin
               cnt_d = 8'd0;
               if (hp_q == hp_last_q) begin
                  state_d = S_HOLD;
               end else begin
                  hp_d  = hp_q + 7'd1;
                  sck_d = ~sck_q;
                  if (sck_q) begin
                     sr_d = {sr_q[38:0], 1'b0};
                  end
               end
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + 8'd1;
            if (tick) begin
               cnt_d   = 8'd0;
               state_d = S_GAP;
               ss_n_d  = 1'b1;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + 8'd1;
            // Registered pulse lands on the final GAP cycle.
            if (cnt_q == DIV_PRE) begin
               done_d = 1'b1;
            end
            if (tick) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef SPI_BOOT_HOST_MISO_CAPTURE_EN
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [7:0] rx_q, rx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh_q <= 8'd0;
         rx_q    <= 8'd0;
      end else begin
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
      end
   end

   always_comb begin
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      if (sck_d && !sck_q) begin
         rx_sh_d = {rx_sh_q[6:0], spi_miso};
      end
      if (done_d) begin
         rx_d = rx_sh_q;
      end
   end

   assign o_rx_byte = rx_q;
`else
   logic unused_miso;
   assign unused_miso = spi_miso;
   assign o_rx_byte   = 8'h00;
`endif

   assign o_req_ready = (state_q == S_IDLE);
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = done_q;
   assign spi_ss_n    = ss_n_q;
   assign spi_sck     = sck_q;
   assign spi_mosi    = sr_q[39];

endmodule

// File: tb/tb_spi_boot_host.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_boot_host: randomized requests, SPI bus monitor, MISO target model.
module tb_spi_boot_host;

   localparam int D  = 4;
   localparam int D2 = 2;

   typedef struct {
      int          nbytes;
      logic [39:0] mosi;
      logic [7:0]  rx;
      int          gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        ready, busy, done;
   logic [7:0]  rx;
   logic        ss_n, sck, mosi;
   logic        miso;

   logic        v2;
   logic [1:0]  op2;
   logic [31:0] data2;
   logic        rdy2, busy2, done2;
   logic [7:0]  rx2;
   logic        ss2, sck2, mosi2;
   logic        miso2;

   exp_t        exp_q[$];
   logic [39:0] miso_q[$];
   logic [7:0]  cmd_tab [4] = '{8'h10, 8'h11, 8'h20, 8'h30};
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   spi_boot_host #(.CLK_DIV(D)) dut (
      .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready),
      .i_req_op(req_op), .i_req_data(req_data), .o_busy(busy), .o_done(done),
      .o_rx_byte(rx), .spi_ss_n(ss_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
   );

   spi_boot_host #(.CLK_DIV(D2)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_req_valid(v2), .o_req_ready(rdy2),
      .i_req_op(op2), .i_req_data(data2), .o_busy(busy2), .o_done(done2),
      .o_rx_byte(rx2), .spi_ss_n(ss2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: frame contents, rx byte and inter-frame gap from the protocol rules.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] data,
                                  input logic [39:0] mpat, input bit b2b);
      exp_t e;
      e.nbytes = (op >= 2'd2) ? 5 : 1;
      e.mosi   = (e.nbytes == 5) ? {cmd_tab[op], data} : {32'd0, cmd_tab[op]};
`ifdef SPI_BOOT_HOST_MISO_CAPTURE_EN
      e.rx     = mpat[39 - 8 * (e.nbytes - 1) -: 8];
`else
      e.rx     = 8'h00;
`endif
      e.gap    = b2b ? D + 1 : -1;
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // MISO target: first bit at ss_n fall, next bit after each SCK fall.
   logic [39:0] tpat = 40'd0;
   bit          t_active = 1'b0;
   initial begin
      miso  = 1'b0;
      miso2 = 1'b0;
      forever begin
         @(ss_n or negedge sck);
         if (ss_n !== 1'b0 || rst_n !== 1'b1) begin
            t_active = 1'b0;
         end else if (!t_active) begin
            t_active = 1'b1;
            tpat = (miso_q.size() > 0) ? miso_q.pop_front() : 40'd0;
            miso = tpat[39];
         end else if (sck === 1'b0) begin
            tpat = {tpat[38:0], 1'b0};
            miso = tpat[39];
         end
      end
   end

   // Monitor: pops an expectation at each frame start, compares at o_done.
   exp_t        cur;
   bit          m_active = 1'b0;
   int          m_t0, m_low, m_rises, m_last_rise, m_bad, m_viol, m_gap;
   logic [39:0] m_got;
   logic        p_ss = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
   initial begin
      m_gap = 0;
      m_viol = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            m_active = 1'b0;
            p_ss = 1'b1;
            p_sck = 1'b0;
            m_gap = 0;
         end else begin
            if (busy && ready) m_viol++;
            if (!ss_n && p_ss) begin
               chk("frame_queued", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  if (cur.gap >= 0) chk("ss_gap", 64'(m_gap), 64'(cur.gap));
                  m_active = 1'b1;
                  m_t0 = cyc;
                  m_low = 0;
                  m_rises = 0;
                  m_last_rise = -1;
                  m_bad = 0;
                  m_viol = 0;
                  m_got = 40'd0;
               end
               m_gap = 0;
            end
            if (ss_n) m_gap++;
            if (m_active) begin
               if (!ss_n) m_low++;
               if (!ss_n && !busy) m_viol++;
               if (sck && !p_sck) begin
                  m_rises++;
                  m_got = {m_got[38:0], mosi};
                  if (m_last_rise >= 0 && cyc - m_last_rise != 2 * D) m_bad++;
                  m_last_rise = cyc;
               end
               if (sck && p_sck && mosi != p_mosi) m_bad++;
               if (done) begin
                  chk("done_time", 64'(cyc - m_t0), 64'(D * (16 * cur.nbytes + 3) - 1));
                  chk("ss_low_cycles", 64'(m_low), 64'(D * (16 * cur.nbytes + 2)));
                  chk("sck_rises", 64'(m_rises), 64'(8 * cur.nbytes));
                  chk("mosi_frame", 64'(m_got), 64'(cur.mosi));
                  chk("rx_byte", 64'(rx), 64'(cur.rx));
                  chk("sck_timing_viol", 64'(m_bad), 64'd0);
                  chk("handshake_viol", 64'(m_viol), 64'd0);
                  m_active = 1'b0;
               end
            end else if (done) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end
            p_ss = ss_n;
            p_sck = sck;
            p_mosi = mosi;
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] data,
                       input logic [39:0] mpat, input bit b2b);
      int n;
      exp_q.push_back(model(op, data, mpat, b2b));
      miso_q.push_back(mpat);
      req_valid = 1'b1;
      req_op = op;
      req_data = data;
      n = 0;
      while (!ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("accept_timeout", 64'(n), 64'd0);
      @(negedge clk);
      req_valid = 1'b0;
      req_op = 2'($urandom);
      req_data = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("idle_timeout", 64'(n), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit          b2b;
      int          off, low, rises;
      logic        psck;
      logic [7:0]  bits;

      rst_n = 1'b0;
      req_valid = 1'b0;
      req_op = 2'd0;
      req_data = 32'd0;
      v2 = 1'b0;
      op2 = 2'd0;
      data2 = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rx", 64'(rx), 64'd0);
      chk("rst_ss_n", 64'(ss_n), 64'd1);
      chk("rst_sck", 64'(sck), 64'd0);
      chk("rst_mosi", 64'(mosi), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(2'd0, $urandom, {$urandom, 8'($urandom)}, 1'b0);
      wait_idle();
      send(2'd3, 32'hDEADBEEF, {32'h12345678, 8'hA5}, 1'b0);
      wait_idle();
      send(2'd2, 32'h00000100, {$urandom, 8'($urandom)}, 1'b0);
      send(2'd1, $urandom, {$urandom, 8'($urandom)}, 1'b1);
      wait_idle();

      // Abort a Write IMEM frame during its third byte.
      send(2'd3, $urandom, {$urandom, 8'($urandom)}, 1'b0);
      repeat (D * 33 + 6) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_ss_n", 64'(ss_n), 64'd1);
      chk("midrst_sck", 64'(sck), 64'd0);
      chk("midrst_mosi", 64'(mosi), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_ready", 64'(ready), 64'd1);
      chk("midrst_rx", 64'(rx), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(2'd1, $urandom, {$urandom, 8'($urandom)}, 1'b0);
      wait_idle();

      for (int i = 0; i < 12; i++) begin
         b2b = (i != 0) && ($urandom_range(0, 2) == 0);
         if (!b2b) begin
            wait_idle();
            repeat ($urandom_range(0, 6)) @(negedge clk);
         end
         send(2'($urandom), $urandom, {$urandom, 8'($urandom)}, b2b);
      end
      wait_idle();
      chk("pending_frames", 64'(exp_q.size()), 64'd0);

      // CLK_DIV=2 instance, Stop frame.
      v2 = 1'b1;
      op2 = 2'd0;
      data2 = $urandom;
      @(negedge clk);
      v2 = 1'b0;
      op2 = 2'd3;
      off = 0;
      low = 0;
      rises = 0;
      psck = 1'b0;
      bits = 8'd0;
      while (off < 200) begin
         if (!ss2) low++;
         if (sck2 && !psck) begin
            rises++;
            bits = {bits[6:0], mosi2};
         end
         psck = sck2;
         if (done2) break;
         @(negedge clk);
         off++;
      end
      chk("div2_done_time", 64'(off), 64'd37);
      chk("div2_ss_low", 64'(low), 64'd36);
      chk("div2_sck_rises", 64'(rises), 64'd8);
      chk("div2_mosi", 64'(bits), 64'h10);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
